// File: rtl/data_memory_arbiter.sv
// Data-memory arbiter: shares one word-wide memory port between the pipeline
// memory stage and the program loader. Sub-word loads are extracted and
// extended here, sub-word stores become a read-modify-write pair, and
// misaligned pipeline accesses are flagged instead of reaching memory.
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_req,
  input  logic                  p_we,
  input  logic [2:0]            p_funct3,
  input  logic [ADDR_WIDTH-1:0] p_addr,
  input  logic [31:0]           p_wdata,
  output logic [31:0]           p_rdata,
  output logic                  p_stall,
  output logic                  misaligned_err,
  input  logic                  l_valid,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [31:0]           l_wdata,
  output logic                  l_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_re,
  output logic                  m_we,
  output logic [31:0]           m_wdata,
  input  logic [31:0]           m_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WRITE} state_e;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              f3_q, f3_d;
  logic [15:0]             wdata_q, wdata_d;

  logic                    p_byte, p_half, p_mis;
  logic [4:0]              lane_sh;
  logic [31:0]             rd_shift, ld_data;
  logic [31:0]             st_mask, st_data, rmw_word;

  // Decode the pipeline request: funct3[1:0] picks the size, undefined codes fall to word
  always_comb begin
    p_byte = (p_funct3[1:0] == 2'b00);
    p_half = (p_funct3[1:0] == 2'b01);
    p_mis  = (p_half & p_addr[0]) | (!p_byte & !p_half & (p_addr[1:0] != 2'b00));
  end

  // Load extraction and store merge, both driven by the captured offset/size
  always_comb begin
    lane_sh  = {addr_q[1:0], 3'b000};
    rd_shift = m_rdata >> lane_sh;
    case (f3_q)
      3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  ld_data = {24'h0, rd_shift[7:0]};
      3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  ld_data = {16'h0, rd_shift[15:0]};
      default: ld_data = m_rdata;
    endcase
    // Only SB/SH reach RMW_WRITE, so f3_q[0] alone separates byte from halfword
    if (f3_q[0]) begin
      st_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
      st_data = {2{wdata_q}};
    end else begin
      st_mask = 32'h0000_00FF << lane_sh;
      st_data = {4{wdata_q[7:0]}};
    end
    rmw_word = (m_rdata & ~st_mask) | (st_data & st_mask);
  end

  // Next-state, capture and port outputs; everything is forced low while in reset
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    f3_d           = f3_q;
    wdata_d        = wdata_q;
    p_rdata        = 32'h0;
    p_stall        = 1'b0;
    misaligned_err = 1'b0;
    l_ready        = 1'b0;
    m_addr         = '0;
    m_re           = 1'b0;
    m_we           = 1'b0;
    m_wdata        = 32'h0;
    case (state_q)
      IDLE: begin
        if (l_valid) begin
          // Loader has priority; a waiting pipeline request simply stalls
          m_we    = 1'b1;
          m_addr  = l_addr & WORD_MASK;
          m_wdata = l_wdata;
          l_ready = 1'b1;
          p_stall = p_req;
        end else if (p_req) begin
          if (p_mis) begin
            misaligned_err = 1'b1;
          end else if (!p_we || !(p_byte || p_half)) begin
            m_addr = p_addr & WORD_MASK;
            if (p_we) begin
              // Full-word store goes straight through
              m_we    = 1'b1;
              m_wdata = p_wdata;
            end else begin
              m_re    = 1'b1;
              p_stall = 1'b1;
              addr_d  = p_addr;
              f3_d    = p_funct3;
              state_d = LOAD_WAIT;
            end
          end else begin
            // Sub-word store: read the old word first, merge next cycle
            m_addr  = p_addr & WORD_MASK;
            m_re    = 1'b1;
            p_stall = 1'b1;
            addr_d  = p_addr;
            f3_d    = p_funct3;
            wdata_d = p_wdata[15:0];
            state_d = RMW_WRITE;
          end
        end
      end
      LOAD_WAIT: begin
        m_addr  = addr_q & WORD_MASK;
        p_rdata = ld_data;
        state_d = IDLE;
      end
      RMW_WRITE: begin
        m_addr  = addr_q & WORD_MASK;
        m_we    = 1'b1;
        m_wdata = rmw_word;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      p_rdata        = 32'h0;
      p_stall        = 1'b0;
      misaligned_err = 1'b0;
      l_ready        = 1'b0;
      m_addr         = '0;
      m_re           = 1'b0;
      m_we           = 1'b0;
      m_wdata        = 32'h0;
    end
  end

  // State and captured request; async reset aborts any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= 3'b000;
      wdata_q <= 16'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of all address ports.
REQ-002 SHALL have clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have p_req  in  1  pipeline memory access request.
REQ-005 SHALL have p_we  in  1  pipeline store (1) / load (0).
REQ-006 SHALL have p_funct3  in  3  RV32I size/sign: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-007 SHALL have p_addr  in  ADDR_WIDTH  pipeline byte address (ALU result).
REQ-008 SHALL have p_wdata  in  32  pipeline store data, low-order bytes significant.
REQ-009 SHALL have p_rdata  out  32  extracted and extended load data.
REQ-010 SHALL have p_stall  out  1  pipeline must hold the memory stage this cycle.
REQ-011 SHALL have misaligned_err  out  1  one-cycle pulse on a misaligned pipeline access.
REQ-012 SHALL have l_valid  in  1  program loader word-write request.
REQ-013 SHALL have l_addr  in  ADDR_WIDTH  loader byte address, word-aligned.
REQ-014 SHALL have l_wdata  in  32  loader write word.
REQ-015 SHALL have l_ready  out  1  loader write accepted this cycle.
REQ-016 SHALL have m_addr  out  ADDR_WIDTH  memory address, bits [1:0] always 00.
REQ-017 SHALL have m_re / m_we  out  1 each  memory read / write strobes, never both high.
REQ-018 SHALL have m_wdata  out  32  memory write word.
REQ-019 SHALL have m_rdata  in  32  memory read word, valid the cycle after m_re.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD_WAIT, RMW_WRITE.
REQ-021 In IDLE, l_valid SHALL win over p_req: m_we=1, m_addr=l_addr, m_wdata=l_wdata, l_ready=1, p_stall=p_req; state stays IDLE.
REQ-022 In IDLE, with no l_valid, a misaligned p_req (halfword addr[0]=1, word addr[1:0]!=00) SHALL pulse misaligned_err, issue no m_re/m_we, keep p_stall=0.
REQ-023 In IDLE, aligned load: m_re=1, p_stall=1, capture addr[1:0] and funct3, go LOAD_WAIT.
REQ-024 In LOAD_WAIT: p_rdata = selected byte/halfword/word of m_rdata, sign-extended (000,001) or zero-extended (100,101); p_stall=0; return IDLE.
REQ-025 In IDLE, aligned SW: m_we=1, m_wdata=p_wdata, p_stall=0, single cycle, stay IDLE.
REQ-026 In IDLE, aligned SB/SH: m_re=1, p_stall=1, capture addr/data/size, go RMW_WRITE.
REQ-027 In RMW_WRITE: m_we=1, m_wdata = m_rdata with targeted byte(s) replaced by captured p_wdata low bits (little-endian lanes), p_stall=0, return IDLE.
REQ-028 Load latency SHALL be exactly 1 stall cycle; SB/SH exactly 1 stall cycle; SW 0.
REQ-029 l_valid arriving in LOAD_WAIT or RMW_WRITE SHALL see l_ready=0 until the next IDLE cycle; no preemption.
REQ-030 p_rdata SHALL be 0 in every state other than LOAD_WAIT.
REQ-031 In IDLE with no request, all strobes, l_ready, p_stall, misaligned_err SHALL be 0.
REQ-032 Undefined funct3 (011, 110, 111) SHALL be treated as word access.

Reset
REQ-033 rst low SHALL force state IDLE and all outputs 0 immediately, independent of clk.
REQ-034 Reset asserted in LOAD_WAIT or RMW_WRITE SHALL abort the access with no m_we issued.
REQ-035 Leaving reset, the first rising edge with rst high SHALL accept requests normally.

Verification
REQ-036 LBU 0x103, m_rdata=0x80FF1234 -> 1 stall cycle, then p_rdata=0x00000080.
REQ-037 LH 0x102, m_rdata=0x80FF1234 -> p_rdata=0xFFFF80FF; LW 0x102 -> misaligned_err=1 one cycle, m_re=0, p_stall=0.
REQ-038 SB 0x201 data 0xAB, old word 0x11223344 -> RMW_WRITE m_wdata=0x1122AB44 at m_addr 0x200.
REQ-039 Simultaneous l_valid and p_req (LW) in IDLE -> loader written, l_ready=1, p_stall=1; next cycle pipeline read issues.
REQ-040 rst low during RMW_WRITE setup cycle -> m_we never asserted, all outputs 0, IDLE after release.
